// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared grid geometry, types and ghost sprite bitmap
package vga_pkg;

  localparam int GRID_W   = 32;
  localparam int GRID_H   = 24;
  localparam int BUF_SIZE = GRID_W * GRID_H;
  localparam int SPR_W    = 4;
  localparam int SPR_H    = 4;

  typedef logic [7:0] color_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DRAW
  } state_t;

  // Indexed [row][column]; colour 0 is transparent.
  localparam color_t [0:3][0:3] SPRITE = '{
    '{8'h00, 8'hE0, 8'hE0, 8'h00},
    '{8'hE0, 8'hFF, 8'hFF, 8'hE0},
    '{8'hE0, 8'hE0, 8'hE0, 8'hE0},
    '{8'hE0, 8'h00, 8'hE0, 8'h00}
  };

endpackage

// File: rtl/ghost_sprite_rom.sv
// rtl/ghost_sprite_rom.sv - combinational sprite pixel lookup by (dx,dy)
module ghost_sprite_rom
  import vga_pkg::*;
(
  input  logic [1:0] dx,
  input  logic [1:0] dy,
  output color_t     color
);

  // Pure table lookup so a different sprite only touches the package.
  always_comb begin
    color = SPRITE[dy][dx];
  end

endmodule

// File: rtl/ghost_renderer.sv
// rtl/ghost_renderer.sv - per-frame ghost movement and blocked-frame streamer
module ghost_renderer
  import vga_pkg::*;
#(
  parameter int     MOVE_DIV = 8,
  parameter color_t BG_COLOR = 8'h00,
  parameter int     GX_INIT  = 14,
  parameter int     GY_INIT  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] write_address,
  output color_t     write_data,
  output logic       busy
);

  localparam int         CNT_W     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);
  localparam logic [4:0] GX_MAX    = 5'(GRID_W - SPR_W);
  localparam logic [4:0] GY_MAX    = 5'(GRID_H - SPR_H);
  localparam logic [9:0] LAST_ADDR = 10'(BUF_SIZE - 1);

  state_t           state;
  state_t           state_next;
  logic [9:0]       addr;
  logic [4:0]       gx;
  logic [4:0]       gy;
  logic [CNT_W-1:0] move_cnt;
  logic             fs_prev;
  logic             fs_cond;
  logic             fs;
  logic             in_move;
  logic             in_draw;

  logic [4:0] bx;
  logic [4:0] by;
  logic [1:0] dx;
  logic [1:0] dy;
  logic       hit;
  color_t     spr_color;

  assign fs_cond = (hc == 10'd0) && (vc == 10'd0);
  assign fs      = fs_cond && !fs_prev;

  // Remember the origin condition so a multi-clock origin yields one pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) fs_prev <= 1'b0;
    else        fs_prev <= fs_cond;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: frame start kicks off MOVE, DRAW ends on the last address.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fs) state_next = MOVE;
      MOVE:    state_next = DRAW;
      DRAW:    if (addr == LAST_ADDR) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    in_move = 1'b0;
    in_draw = 1'b0;
    busy    = 1'b0;
    case (state)
      MOVE:    in_move = 1'b1;
      DRAW:    begin in_draw = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  // Pixel address: rewound in MOVE, walks in DRAW, parks on the last pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= 10'd0;
    end else if (in_move) begin
      addr <= 10'd0;
    end else if (in_draw && addr != LAST_ADDR) begin
      addr <= addr + 10'd1;
    end
  end

  // Sprite position: stepped every MOVE_DIV frames, saturating at the grid edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gx       <= 5'(GX_INIT);
      gy       <= 5'(GY_INIT);
      move_cnt <= '0;
    end else if (in_move) begin
      if (move_cnt == CNT_LAST) begin
        move_cnt <= '0;
        if (btn_left && !btn_right && gx != 5'd0)        gx <= gx - 5'd1;
        else if (btn_right && !btn_left && gx != GX_MAX) gx <= gx + 5'd1;
        if (btn_up && !btn_down && gy != 5'd0)           gy <= gy - 5'd1;
        else if (btn_down && !btn_up && gy != GY_MAX)    gy <= gy + 5'd1;
      end else begin
        move_cnt <= move_cnt + 1'b1;
      end
    end
  end

  assign bx = addr[4:0];
  assign by = addr[9:5];
  // Only the low two bits of the offset matter inside a 4x4 hit window.
  assign dx = bx[1:0] - gx[1:0];
  assign dy = by[1:0] - gy[1:0];

  // Hit window compared in 6 bits so gx+4 cannot wrap at the right edge.
  always_comb begin
    hit = (bx >= gx) && ({1'b0, bx} < ({1'b0, gx} + 6'd4)) &&
          (by >= gy) && ({1'b0, by} < ({1'b0, gy} + 6'd4));
  end

  ghost_sprite_rom u_rom (
    .dx    (dx),
    .dy    (dy),
    .color (spr_color)
  );

  // Colour follows the address combinationally so every write pair is consistent.
  always_comb begin
    write_data = BG_COLOR;
    if (hit && spr_color != 8'h00) write_data = spr_color;
  end

  assign write_address = addr;

endmodule
